// File: rtl/e203_ifu_pkg.sv
// ---------------------------------------------------------------------------
// e203_ifu_pkg
// Shared definitions for the IFU mini-decoder queue:
//   - RV32 major opcodes and funct7 used by the pre-decoder
//   - RVC funct3 codes for the control-transfer instructions
//   - dec_entry_t: one pre-decoded instruction (flags, source registers,
//     sign-extended immediate and branch/jump target)
//   - sext_imm: sign-extends a 32-bit immediate to the entry immediate width
// ---------------------------------------------------------------------------
package e203_ifu_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // RVC funct3 in [15:13]; quadrant in [1:0] disambiguates shared codes
  localparam logic [2:0] C_F3_JAL  = 3'b001;  // quadrant 1 (RV32 only)
  localparam logic [2:0] C_F3_J    = 3'b101;  // quadrant 1
  localparam logic [2:0] C_F3_BEQZ = 3'b110;  // quadrant 1
  localparam logic [2:0] C_F3_BNEZ = 3'b111;  // quadrant 1
  localparam logic [2:0] C_F3_JR   = 3'b100;  // quadrant 2 (c.jr/c.jalr/c.mv/c.add)

  // Entry fields are wide enough for any PC_SIZE/XLEN up to 64; the queue
  // narrows them to its own parameters at the output.
  localparam int DEC_W       = 64;
  localparam int DEC_RFIDX_W = 5;

  typedef struct packed {
    logic                   rv32;
    logic                   bjp;
    logic                   jal;
    logic                   jalr;
    logic                   bxx;
    logic                   beqz_bnez;
    logic                   muldiv;
    logic                   rs1en;
    logic                   rs2en;
    logic [DEC_RFIDX_W-1:0] rs1idx;
    logic [DEC_RFIDX_W-1:0] rs2idx;
    logic [DEC_W-1:0]       imm;
    logic [DEC_W-1:0]       tgt;
  } dec_entry_t;

  function automatic logic [DEC_W-1:0] sext_imm(input logic signed [31:0] v);
    return DEC_W'(v);
  endfunction

endpackage

// File: rtl/e203_ifu_minidec_lite.sv
// ---------------------------------------------------------------------------
// e203_ifu_minidec_lite
// Purely combinational pre-decoder: instruction word -> dec_entry_t.
// Recognises RV32 jal/jalr/branch/mul-div and RVC c.j/c.jal/c.jr/c.jalr/
// c.beqz/c.bnez, extracts source registers and the branch/jump offset.
// The tgt field is left at zero; the queue adds the PC and fills it in.
// Ports:
//   i_instr  in   32  instruction word (RVC in [15:0])
//   o_dec    out  dec_entry_t decoded fields
// ---------------------------------------------------------------------------
module e203_ifu_minidec_lite
  import e203_ifu_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_entry_t  o_dec
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [2:0] w_cf3;
  logic       w_rv32;
  logic       w_q1;
  logic       w_q2;
  logic       w_jal32;
  logic       w_jalr32;
  logic       w_bxx32;
  logic       w_muldiv;
  logic       w_cj;
  logic       w_cjr;
  logic       w_cbz;
  logic signed [31:0] w_imm_j;
  logic signed [31:0] w_imm_i;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_cj;
  logic signed [31:0] w_imm_cb;
  logic signed [31:0] w_imm;

  assign w_opc  = i_instr[6:0];
  assign w_f3   = i_instr[14:12];
  assign w_f7   = i_instr[31:25];
  assign w_cf3  = i_instr[15:13];
  assign w_rv32 = (i_instr[1:0] == 2'b11);
  assign w_q1   = (i_instr[1:0] == 2'b01);
  assign w_q2   = (i_instr[1:0] == 2'b10);

  assign w_jal32  = (w_opc == OPC_JAL);
  assign w_jalr32 = (w_opc == OPC_JALR) && (w_f3 == 3'b000);
  assign w_bxx32  = (w_opc == OPC_BRANCH);
  assign w_muldiv = (w_opc == OPC_OP) && (w_f7 == F7_MULDIV);

  assign w_cj  = w_q1 && ((w_cf3 == C_F3_J) || (w_cf3 == C_F3_JAL));
  // Quadrant-2 funct3=100 also covers c.mv/c.add/c.ebreak; only rs1!=0 with
  // rs2==0 is a register jump (bit 12 picks c.jr vs c.jalr, both are jalr).
  assign w_cjr = w_q2 && (w_cf3 == C_F3_JR) && (|i_instr[11:7]) && !(|i_instr[6:2]);
  assign w_cbz = w_q1 && ((w_cf3 == C_F3_BEQZ) || (w_cf3 == C_F3_BNEZ));

  assign w_imm_j  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_b  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  // CJ scatter: offset[11|4|9:8|10|6|7|3:1|5] lives in [12:2]
  assign w_imm_cj = {{21{i_instr[12]}}, i_instr[8], i_instr[10:9], i_instr[6], i_instr[7],
                     i_instr[2], i_instr[11], i_instr[5:3], 1'b0};
  // CB scatter: offset[8|4:3] in [12:10], offset[7:6|2:1|5] in [6:2]
  assign w_imm_cb = {{24{i_instr[12]}}, i_instr[6:5], i_instr[2], i_instr[11:10],
                     i_instr[4:3], 1'b0};

  always_comb begin
    w_imm = '0;
    if (w_jal32)       w_imm = w_imm_j;
    else if (w_jalr32) w_imm = w_imm_i;
    else if (w_bxx32)  w_imm = w_imm_b;
    else if (w_cj)     w_imm = w_imm_cj;
    else if (w_cbz)    w_imm = w_imm_cb;
  end

  always_comb begin
    o_dec           = '0;
    o_dec.rv32      = w_rv32;
    o_dec.jal       = w_jal32 | w_cj;
    o_dec.jalr      = w_jalr32 | w_cjr;
    o_dec.bxx       = w_bxx32 | w_cbz;
    o_dec.beqz_bnez = w_cbz;
    o_dec.bjp       = w_jal32 | w_cj | w_jalr32 | w_cjr | w_bxx32 | w_cbz;
    o_dec.muldiv    = w_muldiv;
    if (w_rv32) begin
      o_dec.rs1en  = w_jalr32 | w_bxx32 | w_muldiv;
      o_dec.rs2en  = w_bxx32 | w_muldiv;
      o_dec.rs1idx = i_instr[19:15];
      o_dec.rs2idx = i_instr[24:20];
    end else begin
      o_dec.rs1en  = w_cjr | w_cbz;
      o_dec.rs2en  = 1'b0;
      // c.beqz/c.bnez use the 3-bit compressed register field (x8..x15)
      o_dec.rs1idx = w_cbz ? {2'b01, i_instr[9:7]} : i_instr[11:7];
      o_dec.rs2idx = '0;
    end
    o_dec.imm = sext_imm(w_imm);
  end

endmodule

// File: rtl/e203_ifu_minidec_q.sv
// ---------------------------------------------------------------------------
// e203_ifu_minidec_q
// DEPTH-entry FIFO of pre-decoded fetched instructions. Each instruction is
// decoded at enqueue and stored with its PC and precomputed target
// (pc + offset), so every o_* field comes straight from storage.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_valid/i_ready       enqueue handshake; i_instr, i_pc payload
//   i_flush               drop all buffered entries (beats same-cycle enqueue)
//   o_valid/o_ready       dequeue handshake on the head entry
//   o_instr, o_pc         head instruction and PC
//   o_rv32..o_muldiv      head decode flags
//   o_rs1en/o_rs2en, o_rs1idx/o_rs2idx   head source registers
//   o_bjp_imm, o_bjp_tgt  head offset and pc+offset
//   o_count               occupied entries
// ---------------------------------------------------------------------------
module e203_ifu_minidec_q
  import e203_ifu_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [31:0]              i_instr,
  input  logic [PC_SIZE-1:0]       i_pc,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [31:0]              o_instr,
  output logic [PC_SIZE-1:0]       o_pc,
  output logic                     o_rv32,
  output logic                     o_bjp,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_bxx,
  output logic                     o_beqz_bnez,
  output logic                     o_muldiv,
  output logic                     o_rs1en,
  output logic                     o_rs2en,
  output logic [RFIDX_WIDTH-1:0]   o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]   o_rs2idx,
  output logic [XLEN-1:0]          o_bjp_imm,
  output logic [PC_SIZE-1:0]       o_bjp_tgt,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [31:0]        r_instr [DEPTH];
  logic [PC_SIZE-1:0] r_pc    [DEPTH];
  dec_entry_t         r_dec   [DEPTH];

  dec_entry_t         w_dec;
  dec_entry_t         w_ent;
  dec_entry_t         w_head;
  logic [PC_SIZE-1:0] w_tgt;
  logic [AW-1:0]      w_widx;
  logic [AW-1:0]      w_ridx;
  logic               w_full;
  logic               w_empty;
  logic               w_enq;
  logic               w_deq;

  e203_ifu_minidec_lite u_dec (
    .i_instr (i_instr),
    .o_dec   (w_dec)
  );

  // Non-bjp instructions decode to imm=0, so the target degenerates to pc.
  assign w_tgt = i_pc + PC_SIZE'(w_dec.imm);

  always_comb begin
    w_ent     = w_dec;
    w_ent.tgt = DEC_W'(w_tgt);
  end

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);

  assign o_valid = !w_empty;
  assign w_deq   = o_valid && o_ready;
  // Gated by rst_n so the producer sees back-pressure for the whole reset.
  assign i_ready = rst_n && (!w_full || w_deq);
  assign w_enq   = i_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_instr[k] <= '0;
        r_pc[k]    <= '0;
        r_dec[k]   <= '0;
      end
    end else if (i_flush) begin
      // Consumer handshake this cycle is moot: the head is dropped anyway.
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) begin
        r_instr[w_widx] <= i_instr;
        r_pc[w_widx]    <= i_pc;
        r_dec[w_widx]   <= w_ent;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Head read-out: storage -> outputs, no path from i_*.
  assign w_head      = r_dec[w_ridx];
  assign o_instr     = r_instr[w_ridx];
  assign o_pc        = r_pc[w_ridx];
  assign o_rv32      = w_head.rv32;
  assign o_bjp       = w_head.bjp;
  assign o_jal       = w_head.jal;
  assign o_jalr      = w_head.jalr;
  assign o_bxx       = w_head.bxx;
  assign o_beqz_bnez = w_head.beqz_bnez;
  assign o_muldiv    = w_head.muldiv;
  assign o_rs1en     = w_head.rs1en;
  assign o_rs2en     = w_head.rs2en;
  assign o_rs1idx    = RFIDX_WIDTH'(w_head.rs1idx);
  assign o_rs2idx    = RFIDX_WIDTH'(w_head.rs2idx);
  assign o_bjp_imm   = XLEN'(w_head.imm);
  assign o_bjp_tgt   = PC_SIZE'(w_head.tgt);
  assign o_count     = r_wptr - r_rptr;

endmodule

// File: tb/tb_e203_ifu_minidec_q.sv
module tb_e203_ifu_minidec_q;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  flags;  // {rv32,bjp,jal,jalr,bxx,beqz_bnez,muldiv}
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_beqz_bnez, o_muldiv;
  logic        o_rs1en, o_rs2en;
  logic [4:0]  o_rs1idx, o_rs2idx;
  logic [31:0] o_bjp_imm;
  logic [31:0] o_bjp_tgt;
  logic [1:0]  o_count;

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  e203_ifu_minidec_q dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_flush(i_flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_rv32(o_rv32), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
    .o_beqz_bnez(o_beqz_bnez), .o_muldiv(o_muldiv),
    .o_rs1en(o_rs1en), .o_rs2en(o_rs2en), .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx),
    .o_bjp_imm(o_bjp_imm), .o_bjp_tgt(o_bjp_tgt), .o_count(o_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic [6:0] fl,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] imm, input logic [31:0] tgt);
    exp_t e;
    e.instr = ins; e.pc = pc; e.flags = fl; e.rs1 = r1; e.rs2 = r2; e.imm = imm; e.tgt = tgt;
    return e;
  endfunction

  // One clock: drive, settle, score the handshakes about to happen, then clock.
  task automatic cyc(input logic v, input exp_t e, input logic rdy, input logic fl);
    exp_t h;
    i_valid = v; i_instr = e.instr; i_pc = e.pc; o_ready = rdy; i_flush = fl;
    #1;
    if (o_valid && o_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_head", {32'h0, o_instr}, 64'hDEAD_0000);
      end else begin
        h = sbq.pop_front();
        chk("instr", o_instr, h.instr);
        chk("pc", o_pc, h.pc);
        chk("flags", {o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_beqz_bnez, o_muldiv}, h.flags);
        chk("rs1idx", o_rs1idx, h.rs1);
        chk("rs2idx", o_rs2idx, h.rs2);
        chk("bjp_imm", o_bjp_imm, h.imm);
        chk("bjp_tgt", o_bjp_tgt, h.tgt);
        if (!h.flags[6]) chk("rvc_rs2en", o_rs2en, 1'b0);
      end
    end
    if (fl) sbq.delete();
    else if (i_valid && i_ready) sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t nil, v_jal, v_beq, v_cbeqz, v_cjr, v_cj, v_cbnez, v_jalr, v_mul, v_drop, v_flx, v_g;
    exp_t tbl[8];

    nil     = mk(32'h0, 32'h0, 7'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    v_jal   = mk(32'h008000EF, 32'h8000_0000, 7'b1110000, 5'd0, 5'd8, 32'h8, 32'h8000_0008);
    v_beq   = mk(32'hFE208EE3, 32'h100, 7'b1100100, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFC);
    v_cbeqz = mk(32'h0000C001, 32'h200, 7'b0100110, 5'd8, 5'd0, 32'h0, 32'h200);
    v_cjr   = mk(32'h00008082, 32'h204, 7'b0101000, 5'd1, 5'd0, 32'h0, 32'h204);
    v_cj    = mk(32'h0000A009, 32'h300, 7'b0110000, 5'd0, 5'd0, 32'h2, 32'h302);
    v_cbnez = mk(32'h0000FCFD, 32'h400, 7'b0100110, 5'd9, 5'd0, 32'hFFFF_FFFE, 32'h3FE);
    v_jalr  = mk(32'hFF0280E7, 32'h500, 7'b1101000, 5'd5, 5'd16, 32'hFFFF_FFF0, 32'h4F0);
    v_mul   = mk(32'h02208033, 32'h600, 7'b1000001, 5'd1, 5'd2, 32'h0, 32'h600);
    tbl = '{v_jal, v_beq, v_cbeqz, v_cjr, v_cj, v_cbnez, v_jalr, v_mul};

    // Reset held for 3 cycles
    rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_flush = 1'b0; o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_o_count", o_count, 2'd0);
    chk("rst_o_tgt", o_bjp_tgt, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_i_ready", i_ready, 1'b1);

    // Directed decode cases: enqueue alone, check 1-cycle latency, dequeue
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, tbl[i], 1'b0, 1'b0);
      chk("lat_o_valid", o_valid, 1'b1);
      chk("lat_o_count", o_count, 2'd1);
      cyc(1'b0, nil, 1'b1, 1'b0);
      chk("drain_o_valid", o_valid, 1'b0);
    end

    // Fill to DEPTH=2 with consumer stalled, then try a third (must be dropped)
    cyc(1'b1, mk(32'h13 | (32'd0 << 7), 32'h1000, 7'b1000000, 5'd0, 5'd0, 32'h0, 32'h1000), 1'b0, 1'b0);
    cyc(1'b1, mk(32'h13 | (32'd1 << 7), 32'h1004, 7'b1000000, 5'd0, 5'd0, 32'h0, 32'h1004), 1'b0, 1'b0);
    chk("full_count", o_count, 2'd2);
    v_drop = mk(32'h00000F93, 32'hBAD0, 7'b1000000, 5'd0, 5'd0, 32'h0, 32'hBAD0);
    i_valid = 1'b1; o_ready = 1'b0; #1;
    chk("full_i_ready", i_ready, 1'b0);
    cyc(1'b1, v_drop, 1'b0, 1'b0);
    chk("full_hold_count", o_count, 2'd2);
    o_ready = 1'b1; #1;
    chk("full_deq_i_ready", i_ready, 1'b1);

    // Sustained stream through the full queue: 10 more entries across pointer wrap
    for (int k = 2; k < 12; k++)
      cyc(1'b1, mk(32'h13 | (32'(k) << 7), 32'h1000 + 32'(4 * k), 7'b1000000,
                   5'd0, 5'd0, 32'h0, 32'h1000 + 32'(4 * k)), 1'b1, 1'b0);
    chk("stream_count", o_count, 2'd2);
    cyc(1'b0, nil, 1'b1, 1'b0);
    cyc(1'b0, nil, 1'b1, 1'b0);
    chk("stream_empty_valid", o_valid, 1'b0);
    chk("stream_empty_count", o_count, 2'd0);
    chk("stream_sb_empty", sbq.size(), 0);

    // Flush with simultaneous enqueue (and consumer handshake) while full
    cyc(1'b1, v_beq, 1'b0, 1'b0);
    cyc(1'b1, v_cjr, 1'b0, 1'b0);
    v_flx = mk(32'h00000493, 32'h7000, 7'b1000000, 5'd0, 5'd0, 32'h0, 32'h7000);
    cyc(1'b1, v_flx, 1'b1, 1'b1);
    chk("flush_o_valid", o_valid, 1'b0);
    chk("flush_o_count", o_count, 2'd0);
    cyc(1'b0, nil, 1'b1, 1'b0);
    chk("flush_stays_empty", o_valid, 1'b0);
    v_g = mk(32'h00000513, 32'h7100, 7'b1000000, 5'd0, 5'd0, 32'h0, 32'h7100);
    cyc(1'b1, v_g, 1'b0, 1'b0);
    chk("post_flush_count", o_count, 2'd1);
    cyc(1'b0, nil, 1'b1, 1'b0);

    // Reset while an entry is held discards it and clears storage
    cyc(1'b1, v_jal, 1'b0, 1'b0);
    chk("pre_rst_valid", o_valid, 1'b1);
    rst_n = 1'b0; i_valid = 1'b0;
    @(posedge clk); #1;
    sbq.delete();
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_count", o_count, 2'd0);
    chk("mid_rst_instr", o_instr, 32'h0);
    rst_n = 1'b1; #1;
    chk("mid_rst_release_ready", i_ready, 1'b1);
    cyc(1'b1, v_cbnez, 1'b0, 1'b0);
    cyc(1'b0, nil, 1'b1, 1'b0);
    chk("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
